// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential RV32M divider.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    function automatic logic is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shifted;
    logic [WIDTH:0] trial;
    logic           borrow;

    // The shifted remainder is below 2*divisor, so a WIDTH+1 bit difference
    // has its MSB set exactly when the subtraction went negative.
    assign rem_shifted = {rem, quo[WIDTH-1]};
    assign trial       = rem_shifted - {1'b0, divisor_mag};
    assign borrow      = trial[WIDTH];

    assign rem_next = borrow ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with start/busy/done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_reg;
    div_op_e          op_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] dividend_reg;
    logic             sign_q_reg;
    logic             sign_r_reg;
    logic             div_zero_reg;
    logic             ovf_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;

    div_op_e          op_in;
    logic             op_in_signed;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;
    logic [WIDTH-1:0] result_next;

    assign op_in        = div_op_e'(op);
    assign op_in_signed = is_signed(op_in);
    assign dividend_mag = (op_in_signed && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
    assign divisor_mag  = (op_in_signed && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem        (rem_reg),
        .quo        (quo_reg),
        .divisor_mag(divisor_reg),
        .rem_next   (rem_next),
        .quo_next   (quo_next)
    );

    // Sign correction and the RISC-V special cases, consumed in FIX.
    always_comb begin
        quo_final = (is_signed(op_reg) && sign_q_reg) ? (WIDTH'(0) - quo_reg) : quo_reg;
        rem_final = (is_signed(op_reg) && sign_r_reg) ? (WIDTH'(0) - rem_reg) : rem_reg;
        if (div_zero_reg) begin
            quo_final = '1;
            rem_final = dividend_reg;
        end else if (ovf_reg) begin
            quo_final = MIN_NEG;
            rem_final = '0;
        end
        result_next = op_reg[1] ? rem_final : quo_final;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            op_reg       <= OP_DIV;
            count_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            divisor_reg  <= '0;
            dividend_reg <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg       <= op_in;
                        rem_reg      <= '0;
                        quo_reg      <= dividend_mag;
                        divisor_reg  <= divisor_mag;
                        dividend_reg <= dividend;
                        sign_q_reg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_reg   <= dividend[WIDTH-1];
                        div_zero_reg <= (divisor == '0);
                        ovf_reg      <= op_in_signed && (dividend == MIN_NEG) && (divisor == '1);
                        count_reg    <= CW'(WIDTH - 1);
                        busy_reg     <= 1'b1;
                        state_reg    <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    if (count_reg == '0) begin
                        state_reg <= S_FIX;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                S_FIX: begin
                    result_reg <= result_next;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= S_DONE;
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: results, latency, handshake and reset behaviour.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .dividend(dividend),
        .divisor (divisor),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one accepted start and returns result, cycles to done (0 on timeout)
    // and whether busy stayed high in every cycle before done.
    task automatic do_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat, output bit busy_ok);
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_ok = 1'b1; r = 'x;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            if (done) begin
                lat = n;
                r = result;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        $display("op=%0d a=%08h b=%08h -> result=%08h latency=%0d", o, a, b, r, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %08h want 00000000", result); end
        rst_n = 1'b1;
        $display("reset: busy=%b done=%b result=%08h", busy, done, result);
    endtask

    task automatic test_unsigned();
        logic [31:0] r; int lat; bit bok;
        do_div(2'b01, 32'd100, 32'd7, r, lat, bok);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %08h want 0000000e", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency got %0d want 34", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL divu_busy_window got %b want 1", bok); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_pulse got %b want 0", done); end
        do_div(2'b11, 32'd100, 32'd7, r, lat, bok);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %08h want 00000002", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL remu_latency got %0d want 34", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL remu_busy_window got %b want 1", bok); end
    endtask

    task automatic test_signed();
        logic [31:0] r; int lat; bit bok;
        do_div(2'b00, 32'hFFFFFFF9, 32'd2, r, lat, bok);
        checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2 got %08h want fffffffd", r); end
        do_div(2'b10, 32'hFFFFFFF9, 32'd2, r, lat, bok);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_m7_2 got %08h want ffffffff", r); end
        do_div(2'b00, 32'd7, 32'hFFFFFFFE, r, lat, bok);
        checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_m2 got %08h want fffffffd", r); end
        do_div(2'b10, 32'd7, 32'hFFFFFFFE, r, lat, bok);
        checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL rem_7_m2 got %08h want 00000001", r); end
    endtask

    task automatic test_div_zero();
        logic [31:0] r; int lat; bit bok;
        do_div(2'b00, 32'h12345678, 32'h0, r, lat, bok);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by_zero got %08h want ffffffff", r); end
        do_div(2'b01, 32'h12345678, 32'h0, r, lat, bok);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_by_zero got %08h want ffffffff", r); end
        do_div(2'b10, 32'h12345678, 32'h0, r, lat, bok);
        checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL rem_by_zero got %08h want 12345678", r); end
        do_div(2'b11, 32'h12345678, 32'h0, r, lat, bok);
        checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL remu_by_zero got %08h want 12345678", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_zero_latency got %0d want 34", lat); end
    endtask

    task automatic test_overflow();
        logic [31:0] r; int lat; bit bok;
        do_div(2'b00, 32'h80000000, 32'hFFFFFFFF, r, lat, bok);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %08h want 80000000", r); end
        do_div(2'b10, 32'h80000000, 32'hFFFFFFFF, r, lat, bok);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL rem_ovf got %08h want 00000000", r); end
        do_div(2'b01, 32'h80000000, 32'hFFFFFFFF, r, lat, bok);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL divu_ovf_operands got %08h want 00000000", r); end
        do_div(2'b11, 32'h80000000, 32'hFFFFFFFF, r, lat, bok);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL remu_ovf_operands got %08h want 80000000", r); end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [31:0] r;
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 0; r = 'x;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 5) begin
                start = 1'b1; op = 2'b11; dividend = 32'd1000; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = n;
                r = result;
                break;
            end
        end
        start = 1'b0;
        $display("start-while-busy: result=%08h latency=%0d", r, lat);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL ignored_start_result got %08h want 0000000e", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL ignored_start_latency got %0d want 34", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat; bit bok;
        do_div(2'b01, 32'hFFFFFFFF, 32'd1, r, lat, bok);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_first got %08h want ffffffff", r); end
        // do_div starts driving at the next negedge, i.e. the cycle right after done.
        do_div(2'b11, 32'hFFFFFFFF, 32'h10, r, lat, bok);
        checks++; if (r !== 32'h0000000F) begin errors++; $display("FAIL b2b_second got %08h want 0000000f", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_second_latency got %0d want 34", lat); end
    endtask

    task automatic test_reset_mid_op();
        bit saw_done;
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_op_busy_before_reset got %b want 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL mid_reset_result got %08h want 00000000", result); end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_reset_no_done got %b want 0", saw_done); end
        $display("reset mid-op: busy=%b result=%08h done_seen=%b", busy, result, saw_done);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU operations.
- It is the inverse counterpart of the ripple add/sub datapath: it performs repeated shift-and-subtract instead of a single addition.
- It sits beside the ALU and is started by the control path with a start/busy/done handshake.
- Latency is fixed and data-independent.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 4).

Ports:
- clk       input   1      rising-edge clock
- rst_n     input   1      synchronous reset, active low
- start     input   1      request a division; sampled only in IDLE
- op        input   2      operation code: 00=DIV, 01=DIVU, 10=REM, 11=REMU (equals funct3[1:0])
- dividend  input   WIDTH  rs1 value; sampled with start
- divisor   input   WIDTH  rs2 value; sampled with start
- busy      output  1      high while a division is in progress (CALC, FIX)
- done      output  1      one-cycle pulse when result is valid
- result    output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted start

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, result=0; counter and internal registers cleared.
  - Reset mid-operation aborts the division. No done is produced and result reads 0.
- FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - busy=0, done=0.
  - If start=1, latch op and the operand magnitudes (signed ops take two's-complement absolute values).
  - Also latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), plus flags div_zero (divisor==0) and ovf (signed op, dividend=100..0, divisor=all-ones).
  - Clear the partial remainder, load counter=WIDTH-1, go to CALC.
- CALC (exactly WIDTH cycles):
  - Per cycle: {rem,quo} shifted left 1 bit.
  - Trial = rem_shifted - divisor_mag, computed WIDTH+1 bits wide.
  - If the trial is non-negative: rem=trial, quo LSB=1; otherwise keep the shifted rem, quo LSB=0.
  - Exit to FIX when counter==0; otherwise decrement the counter.
- FIX (1 cycle):
  - Select and sign-correct the result, then register it into result.
  - Quotient is negated if sign_q and the op is signed; remainder is negated if sign_r and the op is signed.
  - div_zero overrides: quotient=all-ones (both DIV and DIVU), remainder=original dividend.
  - ovf overrides: quotient=100..0, remainder=0.
- DONE (1 cycle): done=1, busy=0, then go to IDLE.
- Timing:
  - start is high in cycle 0, busy is high in cycles 1..WIDTH+1, and done=1 in cycle WIDTH+2 (34 for WIDTH=32).
  - The earliest next start is accepted in the cycle after done (IDLE).
- Handshake rules:
  - start while busy or in DONE is ignored. Operands are not re-sampled and result is unaffected.
  - Operand and op changes after acceptance have no effect.
- Width rules: all subtraction is carried out in WIDTH+1 bits, so the borrow is the MSB. There are no X-propagating defaults, and every state assigns all registers.
- Illegal or unreachable state encoding: return to IDLE.

Decomposition:
- div_pkg holds:
  - typedef enum logic [1:0] div_op_e {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  - typedef enum logic [1:0] div_state_e {S_IDLE, S_CALC, S_FIX, S_DONE};
  - helper function is_signed(op).
- One natural sub-module: div_step, the combinational single restoring iteration.
  - Inputs: rem, quo, divisor_mag.
  - Outputs: next rem and next quo.
  - It is instantiated once and reused each cycle by seq_divider.

Test Plan:
- DIVU 100/7, and REMU with the same operands -> result=14, then result=2; done exactly 34 cycles after start, busy high for cycles 1..33.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 0x00000001.
- Division by zero, dividend 0x12345678, divisor 0, all four ops -> DIV/DIVU=0xFFFFFFFF; REM/REMU=0x12345678.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> DIV=0x80000000, REM=0x00000000; the same operands with DIVU -> 0x00000000, REMU -> 0x80000000.
- Start pulsed again at cycle 5 with different operands -> ignored; the original result is delivered. Reset asserted at cycle 10 of a later division -> busy=0, result=0 next cycle, no done pulse.
- Back-to-back: DIVU 0xFFFFFFFF/1 is followed, on the cycle after done, by a start for REMU 0xFFFFFFFF/0x10 -> 0xFFFFFFFF, then 0x0000000F. The second done arrives 34 cycles after the second start.
